// File: rtl/arm_mem_pkg.sv
// Shared types for the data memory port.
// Holds size codes, FSM states and lane helpers.
package arm_mem_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 8;
  localparam int DATA_W = LANE_W * LANES;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RESP
  } state_t;

  function automatic logic misaligned(
    input logic [2:0] off,
    input logic [1:0] sz
  );
    logic m;
    unique case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

  // Ones in the low 2^sz bytes.
  function automatic logic [DATA_W-1:0] size_mask(
    input logic [1:0] sz
  );
    logic [DATA_W-1:0] m;
    unique case (sz)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane extract (loads) and merge (stores).
// Ports: offset/size/is_signed/word/wdata in; extracted/merged out.
module mem_lane_align
  import arm_mem_pkg::*;
(
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] extracted,
  output logic [DATA_W-1:0] merged
);

  logic [5:0]        sh;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sbit;

  assign sh      = {offset, 3'b000};
  assign shifted = word >> sh;
  assign mask    = size_mask(size);

  // Dword has no bits to extend into.
  always_comb begin
    sbit = 1'b0;
    unique case (size)
      SZ_B:    sbit = shifted[7];
      SZ_H:    sbit = shifted[15];
      SZ_W:    sbit = shifted[31];
      default: sbit = 1'b0;
    endcase
  end

  assign extracted = (shifted & mask)
                   | ({DATA_W{is_signed & sbit}} & ~mask);

  assign merged = (word & ~(mask << sh))
                | ((wdata & mask) << sh);

endmodule

// File: rtl/data_mem_port.sv
// Load/store controller in front of a 256x64 data RAM.
// Ports: clock/reset, req_* in, resp_* out, ram_* to the RAM.
module data_mem_port
  import arm_mem_pkg::*;
#(
  parameter int WORD_AW = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [WORD_AW+2:0] req_addr,
  input  logic [63:0]        req_wdata,
  output logic               resp_valid,
  output logic               resp_error,
  output logic [63:0]        resp_rdata,
  output logic [WORD_AW-1:0] ram_address,
  output logic               ram_write,
  output logic [63:0]        ram_in,
  input  logic [63:0]        ram_out
);

  state_t             state;
  state_t             nxt;
  logic               wr_q;
  logic [1:0]         size_q;
  logic               sgn_q;
  logic [2:0]         off_q;
  logic [WORD_AW-1:0] idx_q;
  logic [63:0]        data_q;
  logic               err_q;
  logic [63:0]        rdata_q;
  logic [63:0]        ext;
  logic [63:0]        mrg;
  logic               accept;
  logic               mis;

  assign accept = req_valid & (state == ST_IDLE);
  assign mis    = misaligned(req_addr[2:0], req_size);

  mem_lane_align u_align (
    .offset    (off_q),
    .size      (size_q),
    .is_signed (sgn_q),
    .word      (ram_out),
    .wdata     (data_q),
    .extracted (ext),
    .merged    (mrg)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (mis)
            nxt = ST_RESP;
          else if (req_write && req_size == SZ_D)
            nxt = ST_WR;
          else
            nxt = ST_RD;
        end
      end
      ST_RD:   nxt = ST_CAP;
      ST_CAP:  nxt = wr_q ? ST_WR : ST_RESP;
      ST_WR:   nxt = ST_RESP;
      ST_RESP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_B;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        wr_q    <= req_write;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        off_q   <= req_addr[2:0];
        idx_q   <= req_addr[WORD_AW+2:3];
        data_q  <= req_wdata;
        err_q   <= mis;
        rdata_q <= '0;
      end else if (state == ST_CAP) begin
        // Stores keep the merged word for WR.
        if (wr_q)
          data_q <= mrg;
        else
          rdata_q <= ext;
      end
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_error = err_q & resp_valid;
  assign resp_rdata = rdata_q;

  assign ram_write = (state == ST_WR);
  assign ram_in    = ram_write ? data_q : '0;
  assign ram_address =
    (state == ST_RD || state == ST_CAP || state == ST_WR)
    ? idx_q : '0;

endmodule

// File: tb/tb_data_mem_port.sv
// Randomized scoreboard bench for data_mem_port.
// Byte-array reference model, RAM model, decoupled monitor.
module tb_data_mem_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [10:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_error;
  logic [63:0] resp_rdata;
  logic [7:0]  ram_address;
  logic        ram_write;
  logic [63:0] ram_in;
  logic [63:0] ram_out = '0;

  data_mem_port #(.WORD_AW(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_error  (resp_error),
    .resp_rdata  (resp_rdata),
    .ram_address (ram_address),
    .ram_write   (ram_write),
    .ram_in      (ram_in),
    .ram_out     (ram_out)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] init_word(input int i);
    logic [31:0] u;
    u = i;
    if (i == 5) return 64'h0123456789ABCDEF;
    if (i == 2) return 64'h1111111111111111;
    return {u * 32'h9E3779B1, (u + 32'd7) * 32'h85EBCA77};
  endfunction

  logic [63:0] mem [256];
  bit loaded = 0;
  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      loaded <= 1;
    end else begin
      if (ram_write) mem[ram_address] <= ram_in;
      ram_out <= mem[ram_address];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          writes;
    logic [7:0]  word;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  rb [2048];
  int compared = 0;
  int mismatched = 0;
  int wcnt = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        wcnt = 0;
      end else begin
        if (ram_write) begin
          wcnt++;
          if (q.size() > 0)
            chk("wr_addr", 64'(ram_address), 64'(q[0].word));
        end
        if (resp_valid) begin
          if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_resp: got 1 expected 0");
          end else begin
            e = q.pop_front();
            chk("resp_error", 64'(resp_error), 64'(e.err));
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("ram_writes", 64'(wcnt), 64'(e.writes));
          end
          wcnt = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz,
                       input logic sg, input logic [10:0] a,
                       input logic [63:0] wd, output bit got);
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    got = 0;
    for (int t = 0; t < 40; t++) begin
      if (req_ready === 1'b1) begin
        got = 1;
        break;
      end
      @(negedge clock);
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      req_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz,
                       input logic sg, input logic [10:0] a,
                       input logic [63:0] wd);
    exp_t e;
    int n;
    int ai;
    bit got;
    n  = 1 << sz;
    ai = int'(a);
    drive(w, sz, sg, a, wd, got);
    if (!got) return;
    e.acc    = cyc;
    e.word   = a[10:3];
    e.rdata  = '0;
    e.writes = 0;
    e.err    = 1'b0;
    if (ai % n != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (w) begin
      e.lat    = (n == 8) ? 2 : 4;
      e.writes = 1;
      for (int i = 0; i < n; i++) rb[ai+i] = wd[8*i +: 8];
    end else begin
      e.lat = 3;
      for (int i = 0; i < n; i++) e.rdata[8*i +: 8] = rb[ai+i];
      if (sg && n < 8 && e.rdata[8*n-1])
        for (int i = n; i < 8; i++) e.rdata[8*i +: 8] = 8'hFF;
    end
    q.push_back(e);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (q.size() == 0) break;
      @(negedge clock);
    end
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q.size());
      q.delete();
    end
  endtask

  initial begin
    bit got;
    logic [1:0]  sz;
    logic [10:0] a;
    logic [63:0] w;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i);
      for (int k = 0; k < 8; k++) rb[8*i+k] = w[8*k +: 8];
    end
    fork
      monitor();
    join_none
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_ram_write", 64'(ram_write), 64'd0);
    chk("rst_ram_address", 64'(ram_address), 64'd0);
    chk("rst_ram_in", ram_in, 64'd0);

    issue(0, 2'd3, 0, 11'h028, 64'd0);
    issue(0, 2'd0, 1, 11'h02D, 64'd0);
    issue(0, 2'd0, 0, 11'h02D, 64'd0);
    issue(1, 2'd1, 0, 11'h014, 64'hBEEF);
    issue(0, 2'd3, 0, 11'h010, 64'd0);
    issue(0, 2'd2, 0, 11'h006, 64'd0);
    issue(1, 2'd3, 0, 11'h7F8, 64'hDEADBEEFCAFEF00D);
    issue(0, 2'd3, 0, 11'h7F8, 64'd0);
    issue(0, 2'd1, 1, 11'h7FE, 64'd0);
    drain();

    // Abort a sub-word store during its write cycle.
    drive(1, 2'd2, 0, 11'h024, 64'h5555AAAA5555AAAA, got);
    if (got) begin
      @(posedge clock);
      #1 req_valid = 1'b0;
      got = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clock);
        if (ram_write === 1'b1) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        compared++;
        mismatched++;
        $display("FAIL wr_wait_timeout: got 0 expected 1");
      end
      #1 reset = 1'b1;
      #1;
      chk("abort_req_ready", 64'(req_ready), 64'd1);
      chk("abort_resp_valid", 64'(resp_valid), 64'd0);
      chk("abort_ram_write", 64'(ram_write), 64'd0);
      chk("abort_ram_address", 64'(ram_address), 64'd0);
      @(negedge clock);
      #1 reset = 1'b0;
    end
    issue(0, 2'd3, 0, 11'h020, 64'd0);
    issue(1, 2'd2, 0, 11'h024, 64'h0000000012345678);
    issue(0, 2'd3, 0, 11'h020, 64'd0);
    drain();

    for (int n = 0; n < 400; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0)
        a = a & ~(11'(1 << sz) - 11'd1);
      w = {$urandom, $urandom};
      issue(1'($urandom_range(0, 1)), sz,
            1'($urandom_range(0, 1)), a, w);
    end
    req_valid = 1'b0;
    drain();

    repeat (2) @(negedge clock);
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 8; k++) w[8*k +: 8] = rb[8*i+k];
      chk($sformatf("ram_word_%0d", i), mem[i], w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
